tl_ul_sram_responder: RTL

TileLink-UL responder (manager side) terminating the A channel and generating the D channel for a small flop-based scratch memory on the core's peripheral bus. It accepts Get, PutFullData and PutPartialData, applies byte-masked writes, and returns AccessAck/AccessAckData one cycle after acceptance. A one-entry response register with pass-through ready sustains one transaction per cycle.

---
 rtl/tl_ul_sram_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL manager for a small flop-based scratch memory: Get/PutFull/PutPartial
// with byte-masked writes and a one-entry D-channel response register.
module tl_ul_sram_responder #(
   parameter int          DEPTH = 64,
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          SRC_W = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [2:0]       a_opcode,
   input  logic [2:0]       a_param,
   input  logic [1:0]       a_size,
   input  logic [SRC_W-1:0] a_source,
   input  logic [31:0]      a_address,
   input  logic [3:0]       a_mask,
   input  logic [31:0]      a_data,
   input  logic             a_corrupt,
   output logic             d_valid,
   input  logic             d_ready,
   output logic [2:0]       d_opcode,
   output logic [1:0]       d_param,
   output logic [1:0]       d_size,
   output logic [SRC_W-1:0] d_source,
   output logic             d_denied,
   output logic             d_corrupt,
   output logic [31:0]      d_data
);
   localparam int         IDX_W          = $clog2(DEPTH);
   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t           state;
   logic [31:0]      mem [DEPTH];
   logic             fire;
   logic             is_get;
   logic             is_put;
   logic             in_range;
   logic             misaligned;
   logic             mask_bad;
   logic             denied;
   logic [IDX_W-1:0] idx;
   logic [3:0]       exp_mask;
   logic             unused_ok;

   assign unused_ok = ^a_param;

   // Pass-through ready: a draining response frees the slot in the same cycle.
   assign a_ready = (state == S_EMPTY) || d_ready;
   assign fire    = a_valid && a_ready;
   assign d_valid = (state == S_FULL);
   assign d_param = 2'b00;

   assign is_get   = (a_opcode == OP_GET);
   assign is_put   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PARTIAL);
   assign idx      = a_address[IDX_W+1:2];
   assign in_range = (a_address[31:IDX_W+2] == BASE[31:IDX_W+2]);

   always_comb begin
      case (a_size)
         2'd0:    exp_mask = 4'b0001 << a_address[1:0];
         2'd1:    exp_mask = a_address[1] ? 4'b1100 : 4'b0011;
         2'd2:    exp_mask = 4'b1111;
         default: exp_mask = 4'b0000;
      endcase
   end

   assign misaligned = ((a_size == 2'd1) && a_address[0]) ||
                       ((a_size == 2'd2) && (a_address[1:0] != 2'b00));
   assign mask_bad   = ((a_opcode == OP_PUT_FULL) && (a_mask != exp_mask)) ||
                       ((a_opcode == OP_PUT_PARTIAL) && ((a_mask & ~exp_mask) != 4'b0000));
   assign denied     = !(is_get || is_put) || !in_range || (a_size == 2'd3) ||
                       misaligned || mask_bad || (is_put && a_corrupt);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (fire && is_put && !denied) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
         end
      end
   end

   // Response stage: loaded on every fire, held while the consumer stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_EMPTY;
         d_opcode  <= '0;
         d_size    <= '0;
         d_source  <= '0;
         d_denied  <= 1'b0;
         d_corrupt <= 1'b0;
         d_data    <= '0;
      end else if (fire) begin
         state     <= S_FULL;
         d_opcode  <= is_get ? 3'd1 : 3'd0;
         d_size    <= a_size;
         d_source  <= a_source;
         d_denied  <= denied;
         d_corrupt <= denied && is_get;
         d_data    <= (is_get && !denied) ? mem[idx] : '0;
      end else if (d_ready) begin
         state     <= S_EMPTY;
      end
   end
endmodule
